memory_bank_responder: RTL

Memory-side responder for the load/store path. It serves the strobes the memory control FSM issues (mem_enable, mem_read_enable, mem_write_enable) against an internal halfword-wide, byte-lane-writable storage array. A programmable wait-state counter models slow memory. Completion is reported with one-cycle rvalid/wack pulses and a level ready signal, so initiator FSMs and benches have a cycle-accurate memory to talk to.

---
 rtl/memory_pkg.sv | 15 +
 rtl/memory_bank_array.sv | 52 +++++
 rtl/memory_bank_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the memory-side responder and its storage array.
package memory_pkg;

  localparam int unsigned BYTE_LANES = 2;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned MAX_WAIT   = 7;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RESP = 3'd2
  } state_e;

endpackage

// File: rtl/memory_bank_array.sv
// Halfword storage with per-byte-lane synchronous write and a registered read port.
module memory_bank_array
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Array contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        if (be[l]) begin
          mem_q[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_bank_responder.sv
// Cycle-accurate memory responder: accepts one strobe-qualified request at a time,
// inserts programmable wait states, then completes with an rvalid or wack pulse.
module memory_bank_responder
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [BYTE_LANES-1:0] mem_be,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  wack,
  output logic                  prot_err
);

  // Out-of-range wait settings saturate at the counter's capacity.
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic                  wr_q, wr_d;
  logic                  ready_q, ready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wack_q, wack_d;
  logic                  perr_q, perr_d;
  logic                  req_ok;
  logic                  req_both;
  logic                  arr_we;
  logic                  arr_re;

  assign req_ok   = mem_enable & (mem_read_enable ^ mem_write_enable);
  assign req_both = mem_enable & mem_read_enable & mem_write_enable;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    rvalid_d = 1'b0;
    wack_d   = 1'b0;
    perr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_both) begin
          perr_d = 1'b1;
        end else if (req_ok) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          be_d    = mem_be;
          wr_d    = mem_write_enable;
          if (WAIT_EFF == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_EFF - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        rvalid_d = ~wr_q;
        wack_d   = wr_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      perr_q   <= perr_d;
    end
  end

  // The array access happens on the edge that leaves RESP.
  assign arr_we = (state_q == RESP) & wr_q;
  assign arr_re = (state_q == RESP) & ~wr_q;

  memory_bank_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (arr_we),
    .re    (arr_re),
    .be    (be_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign ready    = ready_q;
  assign rvalid   = rvalid_q;
  assign wack     = wack_q;
  assign prot_err = perr_q;

endmodule
